// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the tx arbiter state encoding.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] ST_ARB     = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_WAIT_HI = 2'd2;
  localparam logic [1:0] ST_WAIT_LO = 2'd3;

  typedef enum logic [1:0] {
    ARB     = ST_ARB,
    HOLD    = ST_HOLD,
    WAIT_HI = ST_WAIT_HI,
    WAIT_LO = ST_WAIT_LO
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin pick: first set request after ptr, wrapping.
module rr_arbiter_pick
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  // Scan ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); first hit wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin sharing of one UART transmitter between requesters.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned HOLD_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0]     req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_wr_en,
  output logic [BYTE_W-1:0]             tx_data,
  input  logic                          tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant,
  output logic                          grant_valid,
  output logic                          abort
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W  = (HOLD_TIMEOUT == 0) ? 1 : $clog2(HOLD_TIMEOUT + 1);
  localparam int unsigned TO_LIM = (HOLD_TIMEOUT == 0) ? 0 : HOLD_TIMEOUT - 1;
  localparam bit          TO_EN  = (HOLD_TIMEOUT != 0);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0]  grant_d;
  logic              grant_valid_d;
  logic              tx_wr_en_d;
  logic [BYTE_W-1:0] tx_data_d;
  logic              abort_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  logic [BYTE_W-1:0] req_byte [NUM_REQ];
  logic              acc;
  logic [IDX_W-1:0]  acc_idx;
  logic [BYTE_W-1:0] acc_byte;
  logic              acc_last;
  logic              to_hit;

  rr_arbiter_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Unpack the per-requester byte lanes.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_byte[i] = req_data[i*BYTE_W +: BYTE_W];
    end
  end

  // Transfer this cycle: round-robin winner in ARB, owner only in HOLD.
  always_comb begin
    acc     = 1'b0;
    acc_idx = grant;
    case (state_q)
      ARB: begin
        acc     = pick_any;
        acc_idx = pick_idx;
      end
      HOLD:    acc = req_valid[grant];
      default: acc = 1'b0;
    endcase
    acc_byte = req_byte[acc_idx];
    acc_last = req_last[acc_idx];
  end

  // Ready follows valid of the selected requester; forced low while in reset.
  always_comb begin
    req_ready = '0;
    if (rstb) begin
      case (state_q)
        ARB:     req_ready = pick_gnt;
        HOLD:    req_ready[grant] = req_valid[grant];
        default: req_ready = '0;
      endcase
    end
  end

  assign to_hit = TO_EN && (hold_cnt_q == CNT_W'(TO_LIM));

  // Next-state, ownership and output-register values.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    hold_cnt_d    = '0;
    grant_d       = grant;
    grant_valid_d = grant_valid;
    tx_wr_en_d    = 1'b0;
    tx_data_d     = tx_data;
    abort_d       = 1'b0;
    if (acc) begin
      tx_wr_en_d    = 1'b1;
      tx_data_d     = acc_byte;
      grant_d       = acc_idx;
      grant_valid_d = ~acc_last;
      if (acc_last) rr_ptr_d = acc_idx;
      state_d       = WAIT_HI;
    end else begin
      case (state_q)
        HOLD: begin
          if (to_hit) begin
            abort_d       = 1'b1;
            grant_valid_d = 1'b0;
            rr_ptr_d      = grant;
            state_d       = ARB;
          end else begin
            hold_cnt_d = (&hold_cnt_q) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
          end
        end
        WAIT_HI: if (tx_busy) state_d = WAIT_LO;
        WAIT_LO: if (!tx_busy) state_d = grant_valid ? HOLD : ARB;
        default: state_d = state_q;
      endcase
    end
  end

  // State, pointer, hold counter and registered outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= ARB;
      rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
      hold_cnt_q  <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      tx_wr_en    <= 1'b0;
      tx_data     <= '0;
      abort       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      grant       <= grant_d;
      grant_valid <= grant_valid_d;
      tx_wr_en    <= tx_wr_en_d;
      tx_data     <= tx_data_d;
      abort       <= abort_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter with a packet-level reference model and tx scoreboard.
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ      = 4;
  localparam int unsigned HOLD_TIMEOUT = 8;
  localparam int unsigned IDX_W        = $clog2(NUM_REQ);

  logic                   clk = 1'b0;
  logic                   rstb;
  logic [NUM_REQ-1:0]     req_valid;
  logic [8*NUM_REQ-1:0]   req_data;
  logic [NUM_REQ-1:0]     req_last;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   tx_wr_en;
  logic [7:0]             tx_data;
  logic                   tx_busy;
  logic [IDX_W-1:0]       grant;
  logic                   grant_valid;
  logic                   abort;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .HOLD_TIMEOUT (HOLD_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rstb        (rstb),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_wr_en    (tx_wr_en),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant       (grant),
    .grant_valid (grant_valid),
    .abort       (abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         due;
  } sb_item_t;

  sb_item_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: owner (-1 = none), round-robin pointer, link availability.
  int m_owner, m_ptr, m_grant, m_idle;
  bit m_free, m_seen, m_abort;

  // Requester stimulus: per-requester byte queue {last, byte} and stall counters.
  logic [8:0] rq [NUM_REQ][$];
  int stall [NUM_REQ];
  bit gen_on;
  int max_len, stall_pct, stall_max;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = NUM_REQ - 1;
    m_grant = 0;
    m_idle  = 0;
    m_free  = 1'b1;
    m_seen  = 1'b0;
    m_abort = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"},   req_ready,   0);
    chk({tag, "_tx_wr_en"},    tx_wr_en,    0);
    chk({tag, "_tx_data"},     tx_data,     0);
    chk({tag, "_grant"},       grant,       0);
    chk({tag, "_grant_valid"}, grant_valid, 0);
    chk({tag, "_abort"},       abort,       0);
  endtask

  task automatic gen_packet(input int i);
    int len;
    logic [7:0] b;
    len = $urandom_range(max_len, 1);
    for (int j = 0; j < len; j++) begin
      b = 8'($urandom_range(255, 0));
      rq[i].push_back({(j == len - 1), b});
    end
  endtask

  // Consume handshaken bytes, refill, and present the next byte on each lane.
  task automatic drive(input logic [NUM_REQ-1:0] hs);
    logic [8:0] tmp;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs[i]) begin
        tmp = rq[i].pop_front();
        stall[i] = ($urandom_range(99, 0) < stall_pct) ? $urandom_range(stall_max, 1) : 0;
      end
      if (gen_on && rq[i].size() == 0) gen_packet(i);
      if (stall[i] > 0) begin
        stall[i]--;
        req_valid[i] = 1'b0;
      end else if (rq[i].size() > 0) begin
        tmp = rq[i][0];
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = tmp[7:0];
        req_last[i]        = tmp[8];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  // Record an expected transfer and update ownership.
  task automatic accept(input int w);
    sb_item_t it;
    it.data = req_data[8*w +: 8];
    it.due  = cyc + 1;
    sb.push_back(it);
    m_grant = w;
    m_idle  = 0;
    m_free  = 1'b0;
    m_seen  = 1'b0;
    if (req_last[w]) begin
      m_owner = -1;
      m_ptr   = w;
    end else begin
      m_owner = w;
    end
  endtask

  // One cycle: check registered outputs, predict ready/accept, then drive.
  task automatic step();
    logic [NUM_REQ-1:0] exp_rdy;
    logic [NUM_REQ-1:0] hs;
    int win;
    @(negedge clk);
    chk("grant",       grant,       m_grant);
    chk("grant_valid", grant_valid, (m_owner >= 0));
    chk("abort",       abort,       m_abort);
    m_abort = 1'b0;
    exp_rdy = '0;
    if (m_free) begin
      if (m_owner < 0) begin
        win = -1;
        for (int k = 1; k <= NUM_REQ && win < 0; k++) begin
          if (req_valid[(m_ptr + k) % NUM_REQ]) win = (m_ptr + k) % NUM_REQ;
        end
        if (win >= 0) begin
          exp_rdy[win] = 1'b1;
          accept(win);
        end
      end else if (req_valid[m_owner]) begin
        exp_rdy[m_owner] = 1'b1;
        accept(m_owner);
      end else begin
        m_idle++;
        if (HOLD_TIMEOUT != 0 && m_idle == HOLD_TIMEOUT) begin
          m_abort = 1'b1;
          m_ptr   = m_owner;
          m_owner = -1;
        end
      end
    end else if (!m_seen) begin
      if (tx_busy) m_seen = 1'b1;
    end else if (!tx_busy) begin
      m_free = 1'b1;
    end
    chk("req_ready", req_ready, exp_rdy);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    drive(hs);
  endtask

  function automatic int pending();
    int n;
    n = sb.size();
    for (int i = 0; i < NUM_REQ; i++) n += rq[i].size();
    return n;
  endfunction

  // Assert reset while the owner is between bytes, with every requester valid.
  task automatic reset_mid();
    int guard;
    guard = 0;
    while (!(m_owner >= 0 && m_seen && !m_free) && guard < 500) begin
      step();
      guard++;
    end
    req_valid = '1;
    rstb = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    for (int i = 0; i < NUM_REQ; i++) begin
      rq[i].delete();
      stall[i] = 0;
    end
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("held_rst");
    @(posedge clk);
    #1;
    rstb = 1'b1;
    drive('0);
  endtask

  // Transmitter stand-in: busy rises the cycle after wr_en, stays high 1..4 cycles.
  initial begin : xmit
    logic w;
    int left;
    tx_busy = 1'b0;
    left    = 0;
    forever begin
      @(negedge clk);
      w = tx_wr_en;
      @(posedge clk);
      #1;
      if (!rstb) begin
        tx_busy = 1'b0;
        left    = 0;
      end else if (w) begin
        tx_busy = 1'b1;
        left    = $urandom_range(4, 1);
      end else if (left > 0) begin
        left--;
        if (left == 0) tx_busy = 1'b0;
      end
    end
  end

  // Monitor: every tx write must match the oldest expected transfer.
  initial begin : monitor
    logic prev_wr;
    sb_item_t it;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstb) begin
        prev_wr = 1'b0;
      end else begin
        if (tx_wr_en) begin
          chk("wr_back_to_back", prev_wr, 0);
          chk("wr_while_busy",   tx_busy, 0);
          if (sb.size() == 0) begin
            chk("wr_unexpected", tx_wr_en, 0);
          end else begin
            it = sb.pop_front();
            chk("tx_data",  tx_data, it.data);
            chk("wr_cycle", cyc,     it.due);
          end
        end else if (sb.size() > 0 && sb[0].due < cyc) begin
          it = sb.pop_front();
          chk("wr_missing", tx_wr_en, 1);
        end
        prev_wr = tx_wr_en;
      end
    end
  end

  initial begin : main
    int guard;
    rstb      = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    gen_on    = 1'b0;
    max_len   = 1;
    stall_pct = 0;
    stall_max = 1;
    for (int i = 0; i < NUM_REQ; i++) stall[i] = 0;
    model_reset();
    #1 rstb = 1'b0;
    #2;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rstb   = 1'b1;
    gen_on = 1'b1;
    drive('0);

    // Everyone continuously valid with single-byte packets.
    repeat (200) step();

    // Multi-byte packets with mid-packet stalls, some beyond the timeout.
    max_len   = 4;
    stall_pct = 30;
    stall_max = 12;
    repeat (2000) step();

    reset_mid();
    repeat (1500) step();

    // Drain remaining traffic.
    gen_on    = 1'b0;
    stall_pct = 0;
    guard     = 0;
    while (pending() > 0 && guard < 3000) begin
      step();
      guard++;
    end
    chk("drain_done", pending(), 0);
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
